// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: control/select inputs and the registered decode outputs.
interface decoder_scan_if #(
    parameter int unsigned N       = 2,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned NOUT = 1 << N;

    logic                E;
    logic                mode;
    logic [N-1:0]        A;
    logic [DWELL_W-1:0]  dwell;
    logic [0:NOUT-1]     D;
    logic [N-1:0]        idx;
    logic                wrap;

    modport master (output E, mode, A, dwell, input D, idx, wrap);
    modport slave  (input E, mode, A, dwell, output D, idx, wrap);
endinterface

// File: rtl/decoder_scan.sv
// Active-low N-to-2**N decoder with a static mode and a dwell-timed auto-scan mode.
// Every output is registered; D always decodes the registered idx.
module decoder_scan #(
    parameter int unsigned N       = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    decoder_scan_if.slave  bus
);
    localparam int unsigned NOUT = 1 << N;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCAN   = 2'd1,
        ST_PAUSE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [0:NOUT-1]     d_q, d_d;
    logic                wrap_q, wrap_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STATIC;
            idx_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state and next outputs; D is decoded from idx_d so both land on the same edge
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        d_d     = '1;
        wrap_d  = 1'b0;

        if (!bus.mode) begin
            state_d = ST_STATIC;
            idx_d   = bus.A;
            cnt_d   = '0;
            if (!bus.E) d_d[idx_d] = 1'b0;
        end else begin
            unique case (state_q)
                ST_STATIC: begin
                    state_d = bus.E ? ST_PAUSE : ST_SCAN;
                    idx_d   = bus.A;
                    cnt_d   = '0;
                    if (!bus.E) d_d[idx_d] = 1'b0;
                end
                ST_SCAN, ST_PAUSE: begin
                    if (bus.E) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_SCAN;
                        // >= so a dwell lowered below cnt ends the step immediately
                        if (cnt_q >= bus.dwell) begin
                            cnt_d  = '0;
                            idx_d  = idx_q + N'(1);
                            wrap_d = (idx_q == {N{1'b1}});
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                        end
                        d_d[idx_d] = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_STATIC;
                    idx_d   = bus.A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule
